// File: rtl/instr_register_pipe.sv
// Instruction register with evaluate-on-load ALU, per-entry valid bits and a registered read port.
// Define INSTR_REG_AUTOPTR_EN to take the write address from an internal wrapping counter.
module instr_register_pipe #(
    parameter int OP_WIDTH   = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int OPC_WIDTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      load_en,
    input  logic [OPC_WIDTH-1:0]      opcode,
    input  logic [OP_WIDTH-1:0]       operand_a,
    input  logic [OP_WIDTH-1:0]       operand_b,
    input  logic [ADDR_WIDTH-1:0]     write_pointer,
    input  logic                      read_en,
    input  logic [ADDR_WIDTH-1:0]     read_pointer,
    output logic                      instr_valid,
    output logic [OPC_WIDTH-1:0]      instr_opcode,
    output logic [OP_WIDTH-1:0]       instr_op_a,
    output logic [OP_WIDTH-1:0]       instr_op_b,
    output logic [2*OP_WIDTH-1:0]     instr_result,
    output logic                      instr_err,
    output logic [ADDR_WIDTH:0]       num_valid,
    output logic [ADDR_WIDTH-1:0]     wr_ptr_q
);

    localparam int RES_WIDTH = 2 * OP_WIDTH;

    localparam logic [OPC_WIDTH-1:0] OPC_ZERO  = OPC_WIDTH'(4'd0);
    localparam logic [OPC_WIDTH-1:0] OPC_PASSA = OPC_WIDTH'(4'd1);
    localparam logic [OPC_WIDTH-1:0] OPC_PASSB = OPC_WIDTH'(4'd2);
    localparam logic [OPC_WIDTH-1:0] OPC_ADD   = OPC_WIDTH'(4'd3);
    localparam logic [OPC_WIDTH-1:0] OPC_SUB   = OPC_WIDTH'(4'd4);
    localparam logic [OPC_WIDTH-1:0] OPC_MULT  = OPC_WIDTH'(4'd5);
    localparam logic [OPC_WIDTH-1:0] OPC_DIV   = OPC_WIDTH'(4'd6);
    localparam logic [OPC_WIDTH-1:0] OPC_MOD   = OPC_WIDTH'(4'd7);

    localparam logic signed [RES_WIDTH-1:0] RES_ONE = {{(RES_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]         CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Returns {err, result}; operands are sign-extended first so no operation can overflow.
    function automatic logic [RES_WIDTH:0] calc_result(
        input logic [OPC_WIDTH-1:0] opc,
        input logic [OP_WIDTH-1:0]  a,
        input logic [OP_WIDTH-1:0]  b
    );
        logic signed [RES_WIDTH-1:0] sa;
        logic signed [RES_WIDTH-1:0] sb;
        logic signed [RES_WIDTH-1:0] sb_safe;
        logic signed [RES_WIDTH-1:0] quo;
        logic signed [RES_WIDTH-1:0] rem;
        logic signed [RES_WIDTH-1:0] res;
        logic                        err;
        logic                        b_zero;
        sa      = {{OP_WIDTH{a[OP_WIDTH-1]}}, a};
        sb      = {{OP_WIDTH{b[OP_WIDTH-1]}}, b};
        b_zero  = (b == {OP_WIDTH{1'b0}});
        sb_safe = b_zero ? RES_ONE : sb;
        quo     = sa / sb_safe;
        rem     = sa % sb_safe;
        res     = {RES_WIDTH{1'b0}};
        err     = 1'b0;
        case (opc)
            OPC_ZERO:  res = {RES_WIDTH{1'b0}};
            OPC_PASSA: res = sa;
            OPC_PASSB: res = sb;
            OPC_ADD:   res = sa + sb;
            OPC_SUB:   res = sa - sb;
            OPC_MULT:  res = sa * sb;
            OPC_DIV: begin
                err = b_zero;
                res = b_zero ? {RES_WIDTH{1'b0}} : quo;
            end
            OPC_MOD: begin
                err = b_zero;
                res = b_zero ? {RES_WIDTH{1'b0}} : rem;
            end
            default: begin
                err = 1'b1;
                res = {RES_WIDTH{1'b0}};
            end
        endcase
        return {err, res};
    endfunction

    logic [OPC_WIDTH-1:0]  mem_opc_r [DEPTH];
    logic [OP_WIDTH-1:0]   mem_a_r   [DEPTH];
    logic [OP_WIDTH-1:0]   mem_b_r   [DEPTH];
    logic [RES_WIDTH-1:0]  mem_res_r [DEPTH];
    logic [DEPTH-1:0]      mem_err_r;
    logic [DEPTH-1:0]      valid_r;
    logic [ADDR_WIDTH:0]   num_valid_r;
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] wa_s;
    logic [RES_WIDTH-1:0]  calc_res_s;
    logic                  calc_err_s;

    logic                  out_valid_r;
    logic [OPC_WIDTH-1:0]  out_opc_r;
    logic [OP_WIDTH-1:0]   out_a_r;
    logic [OP_WIDTH-1:0]   out_b_r;
    logic [RES_WIDTH-1:0]  out_res_r;
    logic                  out_err_r;

`ifdef INSTR_REG_AUTOPTR_EN
    logic unused_write_pointer_s;
    assign unused_write_pointer_s = ^write_pointer;

    // Auto write pointer: advances on every accepted load, wrapping at DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {ADDR_WIDTH{1'b0}};
        end else if (load_en) begin
            wr_ptr_r <= wr_ptr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
    end
    assign wa_s = wr_ptr_r;
`else
    assign wr_ptr_r = {ADDR_WIDTH{1'b0}};
    assign wa_s     = write_pointer;
`endif

    // Evaluate the incoming instruction so it is stored on the load edge.
    always_comb begin
        calc_res_s = {RES_WIDTH{1'b0}};
        calc_err_s = 1'b0;
        if (load_en) begin
            {calc_err_s, calc_res_s} = calc_result(opcode, operand_a, operand_b);
        end else begin
            calc_err_s = 1'b0;
            calc_res_s = {RES_WIDTH{1'b0}};
        end
    end

    // Entry storage; cleared on reset so invalid entries always hold zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_opc_r[i] <= {OPC_WIDTH{1'b0}};
                mem_a_r[i]   <= {OP_WIDTH{1'b0}};
                mem_b_r[i]   <= {OP_WIDTH{1'b0}};
                mem_res_r[i] <= {RES_WIDTH{1'b0}};
            end
            mem_err_r <= {DEPTH{1'b0}};
        end else if (load_en) begin
            mem_opc_r[wa_s] <= opcode;
            mem_a_r[wa_s]   <= operand_a;
            mem_b_r[wa_s]   <= operand_b;
            mem_res_r[wa_s] <= calc_res_s;
            mem_err_r[wa_s] <= calc_err_s;
        end
    end

    // Valid bits and occupancy; only a first write to an entry grows the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r     <= {DEPTH{1'b0}};
            num_valid_r <= {(ADDR_WIDTH+1){1'b0}};
        end else if (load_en) begin
            valid_r[wa_s] <= 1'b1;
            if (!valid_r[wa_s]) begin
                num_valid_r <= num_valid_r + CNT_ONE;
            end
        end
    end

    // Registered read port: samples pre-write contents, so a same-address write is seen next read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            out_opc_r   <= {OPC_WIDTH{1'b0}};
            out_a_r     <= {OP_WIDTH{1'b0}};
            out_b_r     <= {OP_WIDTH{1'b0}};
            out_res_r   <= {RES_WIDTH{1'b0}};
            out_err_r   <= 1'b0;
        end else if (read_en) begin
            if (valid_r[read_pointer]) begin
                out_valid_r <= 1'b1;
                out_opc_r   <= mem_opc_r[read_pointer];
                out_a_r     <= mem_a_r[read_pointer];
                out_b_r     <= mem_b_r[read_pointer];
                out_res_r   <= mem_res_r[read_pointer];
                out_err_r   <= mem_err_r[read_pointer];
            end else begin
                out_valid_r <= 1'b0;
                out_opc_r   <= {OPC_WIDTH{1'b0}};
                out_a_r     <= {OP_WIDTH{1'b0}};
                out_b_r     <= {OP_WIDTH{1'b0}};
                out_res_r   <= {RES_WIDTH{1'b0}};
                out_err_r   <= 1'b0;
            end
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign instr_valid  = out_valid_r;
    assign instr_opcode = out_opc_r;
    assign instr_op_a   = out_a_r;
    assign instr_op_b   = out_b_r;
    assign instr_result = out_res_r;
    assign instr_err    = out_err_r;
    assign num_valid    = num_valid_r;
    assign wr_ptr_q     = wr_ptr_r;

endmodule

// File: tb/tb_instr_register_pipe.sv
// Scoreboard bench for instr_register_pipe; INSTR_REG_AUTOPTR_EN selects the auto-pointer scenario.
module tb_instr_register_pipe;

`ifdef INSTR_REG_AUTOPTR_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 32;
`endif
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic        valid;
        logic [3:0]  opc;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
        logic        err;
    } ent_t;

    logic          clk;
    logic          reset_n;
    logic          load_en;
    logic [3:0]    opcode;
    logic [31:0]   operand_a;
    logic [31:0]   operand_b;
    logic [AW-1:0] write_pointer;
    logic          read_en;
    logic [AW-1:0] read_pointer;
    logic          instr_valid;
    logic [3:0]    instr_opcode;
    logic [31:0]   instr_op_a;
    logic [31:0]   instr_op_b;
    logic [63:0]   instr_result;
    logic          instr_err;
    logic [AW:0]   num_valid;
    logic [AW-1:0] wr_ptr_q;

    int   n_vec;
    int   n_miss;
    ent_t m_mem [DEPTH];
    int   m_cnt;
    int   m_ptr;
    ent_t last_out;
    ent_t exp_q [$];

    instr_register_pipe #(.OP_WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .OPC_WIDTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .load_en(load_en), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b), .write_pointer(write_pointer),
        .read_en(read_en), .read_pointer(read_pointer), .instr_valid(instr_valid),
        .instr_opcode(instr_opcode), .instr_op_a(instr_op_a), .instr_op_b(instr_op_b),
        .instr_result(instr_result), .instr_err(instr_err), .num_valid(num_valid),
        .wr_ptr_q(wr_ptr_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_calc(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                                       output logic [63:0] r, output logic e);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = 64'd0;
        e = 1'b0;
        case (opc)
            4'd0: r = 64'd0;
            4'd1: r = sa;
            4'd2: r = sb;
            4'd3: r = sa + sb;
            4'd4: r = sa - sb;
            4'd5: r = sa * sb;
            4'd6: if (sb == 0) e = 1'b1; else r = sa / sb;
            4'd7: if (sb == 0) e = 1'b1; else r = sa % sb;
            default: e = 1'b1;
        endcase
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_cnt    = 0;
        m_ptr    = 0;
        last_out = '0;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_valid"}, 64'(instr_valid), 64'd0);
        check_val({tag, "_opc"},   64'(instr_opcode), 64'd0);
        check_val({tag, "_a"},     64'(instr_op_a), 64'd0);
        check_val({tag, "_b"},     64'(instr_op_b), 64'd0);
        check_val({tag, "_res"},   instr_result, 64'd0);
        check_val({tag, "_err"},   64'(instr_err), 64'd0);
        check_val({tag, "_nv"},    64'(num_valid), 64'd0);
        check_val({tag, "_ptr"},   64'(wr_ptr_q), 64'd0);
    endtask

    // One clock: drive at negedge, push expectation, update model at posedge, compare #1 later.
    task automatic cycle(input logic ld, input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                         input logic [AW-1:0] wp, input logic rd, input logic [AW-1:0] rp);
        ent_t nxt;
        ent_t got;
        int   wa;
        @(negedge clk);
        load_en = ld; opcode = opc; operand_a = a; operand_b = b;
        write_pointer = wp; read_en = rd; read_pointer = rp;
        if (rd) begin
            nxt = m_mem[rp].valid ? m_mem[rp] : '0;
        end else begin
            nxt = last_out;
            nxt.valid = 1'b0;
        end
        exp_q.push_back(nxt);
        last_out = nxt;
        @(posedge clk);
        if (ld) begin
`ifdef INSTR_REG_AUTOPTR_EN
            wa = m_ptr;
            m_ptr = (m_ptr + 1) % DEPTH;
`else
            wa = int'(wp);
`endif
            if (!m_mem[wa].valid) m_cnt++;
            m_mem[wa].valid = 1'b1;
            m_mem[wa].opc = opc;
            m_mem[wa].a = a;
            m_mem[wa].b = b;
            model_calc(opc, a, b, m_mem[wa].res, m_mem[wa].err);
        end
        #1;
        got = exp_q.pop_front();
        check_val("valid",  64'(instr_valid), 64'(got.valid));
        check_val("opcode", 64'(instr_opcode), 64'(got.opc));
        check_val("op_a",   64'(instr_op_a), 64'(got.a));
        check_val("op_b",   64'(instr_op_b), 64'(got.b));
        check_val("result", instr_result, got.res);
        check_val("err",    64'(instr_err), 64'(got.err));
        check_val("num_valid", 64'(num_valid), 64'(m_cnt));
        check_val("wr_ptr", 64'(wr_ptr_q), 64'(m_ptr));
    endtask

    initial begin
        longint tbl [8];
        n_vec = 0;
        n_miss = 0;
        model_clear();
        tbl = '{0, -7, 3, -4, -10, -21, -2, -1};

        reset_n = 1'b0; load_en = 1'b1; opcode = 4'd3; operand_a = 32'd5; operand_b = 32'd5;
        write_pointer = '0; read_en = 1'b1; read_pointer = '0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_outputs_zero("rst");
        end
        @(negedge clk);
        reset_n = 1'b1; load_en = 1'b0; read_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 4'd0, 32'd0, 32'd0, '0, 1'b1, AW'(i));

`ifdef INSTR_REG_AUTOPTR_EN
        for (int i = 0; i < 6; i++) cycle(1'b1, 4'd1, 32'(100 + i), 32'd0, AW'(3), 1'b0, '0);
        check_val("ap_ptr", 64'(wr_ptr_q), 64'd2);
        check_val("ap_nv", 64'(num_valid), 64'd4);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 4'd0, 32'd0, 32'd0, '0, 1'b1, AW'(i));
            check_val("ap_res", instr_result, (i < 2) ? 64'(104 + i) : 64'(100 + i));
        end
`else
        for (int i = 0; i < 8; i++) cycle(1'b1, 4'(i), -32'sd7, 32'sd3, AW'(i), 1'b0, '0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 4'd0, 32'd0, 32'd0, '0, 1'b1, AW'(i));
            check_val("t2_res", instr_result, 64'(tbl[i]));
            check_val("t2_err", 64'(instr_err), 64'd0);
            check_val("t2_valid", 64'(instr_valid), 64'd1);
        end

        cycle(1'b1, 4'd6, 32'd10, 32'd0, AW'(8), 1'b0, '0);
        cycle(1'b1, 4'd9, 32'd3, 32'd4, AW'(9), 1'b0, '0);
        cycle(1'b1, 4'd5, 32'h7FFF_FFFF, 32'h7FFF_FFFF, AW'(10), 1'b0, '0);
        cycle(1'b0, 4'd0, 32'd0, 32'd0, '0, 1'b1, AW'(8));
        check_val("div0_res", instr_result, 64'd0);
        check_val("div0_err", 64'(instr_err), 64'd1);
        cycle(1'b0, 4'd0, 32'd0, 32'd0, '0, 1'b1, AW'(9));
        check_val("ill_res", instr_result, 64'd0);
        check_val("ill_err", 64'(instr_err), 64'd1);
        cycle(1'b0, 4'd0, 32'd0, 32'd0, '0, 1'b1, AW'(10));
        check_val("mult_res", instr_result, 64'h3FFF_FFFF_0000_0001);
        check_val("mult_err", 64'(instr_err), 64'd0);

        cycle(1'b1, 4'd3, 32'd1, 32'd1, AW'(5), 1'b0, '0);
        cycle(1'b1, 4'd3, 32'd4, 32'd4, AW'(5), 1'b1, AW'(5));
        check_val("coll_old", instr_result, 64'd2);
        cycle(1'b0, 4'd0, 32'd0, 32'd0, '0, 1'b1, AW'(5));
        check_val("coll_new", instr_result, 64'd8);
        check_val("coll_nv", 64'(num_valid), 64'd11);

        for (int i = 0; i < 10; i++) cycle(1'b1, 4'd3, 32'(i), 32'd1, AW'(12 + i), 1'b0, '0);
        cycle(1'b0, 4'd0, 32'd0, 32'd0, '0, 1'b1, AW'(12));
        check_val("pre_rst_valid", 64'(instr_valid), 64'd1);
        @(negedge clk);
        #2;
        reset_n = 1'b0; load_en = 1'b0; read_en = 1'b0;
        #1;
        check_outputs_zero("arst");
        model_clear();
        @(posedge clk);
        #1;
        check_outputs_zero("arst_hold");
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 22; i++) cycle(1'b0, 4'd0, 32'd0, 32'd0, '0, 1'b1, AW'(i));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/instr_register_pipe.md
Name: instr_register_pipe

Overview:
Parametrised successor to the lab instruction register. It stores DEPTH instruction words, each holding an opcode, signed operands A and B, a computed result and an error flag. The result is evaluated on the load cycle. The block is read through a registered, one-cycle-latency read port with per-entry valid tracking and an occupancy count. It connects to the testbench through the lab interface, as the DUT modport, in place of instr_register.

Parameters:
- OP_WIDTH, 32, width of signed operands A and B.
- DEPTH, 32, number of entries; must be a power of 2, at least 2.
- ADDR_WIDTH, $clog2(DEPTH), pointer width.
- OPC_WIDTH, 4, opcode width.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- load_en, input, 1, write strobe.
- opcode, input, OPC_WIDTH, operation code.
- operand_a, input, OP_WIDTH, signed operand A.
- operand_b, input, OP_WIDTH, signed operand B.
- write_pointer, input, ADDR_WIDTH, write address.
- read_en, input, 1, read strobe.
- read_pointer, input, ADDR_WIDTH, read address.
- instr_valid, output, 1, read-data qualifier.
- instr_opcode, output, OPC_WIDTH, stored opcode.
- instr_op_a, output, OP_WIDTH, stored operand A.
- instr_op_b, output, OP_WIDTH, stored operand B.
- instr_result, output, 2*OP_WIDTH, stored signed result.
- instr_err, output, 1, stored error flag.
- num_valid, output, ADDR_WIDTH+1, count of valid entries.
- wr_ptr_q, output, ADDR_WIDTH, internal write pointer (see Optional Feature).

Behaviour:
- Reset (reset_n=0, asynchronous):
  - all entries and valid bits cleared;
  - every output forced to 0;
  - takes effect immediately, including mid-operation;
  - deassertion is sampled at the next clk edge.
- Opcodes:
  - 0 ZERO: result=0.
  - 1 PASSA: result=A.
  - 2 PASSB: result=B.
  - 3 ADD: result=A+B.
  - 4 SUB: result=A-B.
  - 5 MULT: result=A*B, full product.
  - 6 DIV: result=A/B, truncates toward zero.
  - 7 MOD: result=A%B, sign follows A.
  - 8..2^OPC_WIDTH-1: illegal.
- Arithmetic: operands are sign-extended to 2*OP_WIDTH before the operation, so there is no overflow.
- Errors:
  - DIV or MOD with B=0: result=0, err=1.
  - Illegal opcode: result=0, err=1.
  - Otherwise err=0.
- Write, at an edge with load_en=1:
  - entry[wa] <= {opcode, A, B, result, err};
  - valid[wa] <= 1;
  - wa = write_pointer, or wr_ptr_q with the feature enabled;
  - overwriting a valid entry is allowed and num_valid is unchanged;
  - a write to an invalid entry increments num_valid.
  - num_valid saturates naturally at DEPTH and never exceeds it.
- Read, at edge N with read_en=1:
  - outputs register entry[read_pointer] and instr_valid <= valid[read_pointer];
  - data is visible after edge N, i.e. one-cycle latency.
- read_en=0:
  - instr_valid <= 0;
  - data outputs hold their previous values.
- Reading an invalid entry: all data outputs 0, instr_valid=0.
- Read and write to the same address in the same cycle: read returns the old contents (read-before-write); the new data is visible on the next read.
- Pointers are ADDR_WIDTH wide, so every value addresses a real entry and no bounds check is needed.
- No backpressure: load_en and read_en are accepted every cycle.

Optional Feature:
- Macro: INSTR_REG_AUTOPTR_EN.
- Defined:
  - the write address is an internal counter wr_ptr_q;
  - wr_ptr_q resets to 0 and increments by 1 on every accepted load;
  - it wraps from DEPTH-1 to 0;
  - the write_pointer input is ignored.
- Not defined:
  - the write address is write_pointer;
  - wr_ptr_q is tied to 0.
- The port list is identical in both builds.

Test Plan:
1. Reset:
   - reset_n=0 for 2 cycles with load_en=1 driven throughout.
   - Expect all outputs 0 and num_valid=0.
   - Then read every address 0..DEPTH-1: instr_valid=0, result=0.
2. Arithmetic, A=-7, B=3:
   - load opcodes 0..7 to addresses 0..7.
   - Expected results: 0, -7, 3, -4, -10, -21, -2, -1; err=0.
   - Each read is valid one cycle after read_en.
3. Errors:
   - load DIV with A=10, B=0 -> result 0, err 1.
   - load opcode 9 -> result 0, err 1.
   - MULT with A=B=32'h7FFFFFFF -> result 64'h3FFFFFFF00000001.
4. Same-address collision:
   - entry 5 holds ADD 1,1 (result 2).
   - In one cycle, load ADD 4,4 to address 5 and read_en at address 5.
   - The read returns 2; a read on the next cycle returns 8.
   - num_valid is unchanged.
5. Async reset mid-operation:
   - after 10 loads, drop reset_n between clock edges.
   - Outputs go to 0 before the next edge; num_valid=0.
   - Previously written addresses read back invalid.
6. With INSTR_REG_AUTOPTR_EN, DEPTH=4:
   - 6 loads with write_pointer fixed at 3.
   - Entries written in order 0,1,2,3,0,1.
   - wr_ptr_q ends at 2; num_valid=4.
